prbs_rx_monitor: RTL and testbench
==================================

// Module: prbs_rx_monitor
// PURPOSE
//   Receive-side PRBS-31 monitor on one lane of the user RX AXIS interface.
//   It self-synchronises to the incoming stream, then counts errored bits, errored
//   words, good frames and bad frames. It is the far end of the per-lane PRBS
//   generator and feeds lane status and counters to debug_o and the status registers.
// PARAMETERS
//   LOCK_CNT     16    consecutive matching full words needed to enter LOCKED
//   LOSS_THRESH  4     consecutive errored words in LOCKED that force HUNT
//   CNT_W        32    width of every statistics counter
//   FRAME_BYTES  1024  expected frame length in bytes (used only with PRBS_RX_MON_LEN_CHECK_EN)
// PORTS
//   rx_user_clk_i    in   1      user RX clock; the only clock in this block
//   rx_user_rst_n_i  in   1      asynchronous active-low reset
//   rx_data_i        in   32     beat data; byte0 = [7:0] is first on the wire
//   rx_vldb_i        in   2      valid bytes on a last beat: 0=4, 1=1, 2=2, 3=3
//   rx_valid_i       in   1      beat qualifier; no ready signal, always accepted
//   rx_last_i        in   1      last beat of a frame
//   rx_user_i        in   1      on a last beat: frame errored (bad FCS or PHY error)
//   clear_i          in   1      synchronous clear of all counters
//   locked_o         out  1      1 while in LOCKED
//   err_o            out  1      1-cycle pulse per errored word while LOCKED
//   err_bit_cnt_o    out  CNT_W  saturating count of errored bits
//   err_word_cnt_o   out  CNT_W  saturating count of errored words
//   frame_cnt_o      out  CNT_W  saturating count of good frames
//   bad_frame_cnt_o  out  CNT_W  saturating count of bad frames
// BEHAVIOUR
//   Reset: every output is 0, the FSM is in HUNT, and the LFSR state is 0.
//   Sequence: b[n] = b[n-31] ^ b[n-28]. Word k carries b[32k+j] on data[j]. The LFSR
//     advances 32 bits on every accepted beat (rx_valid_i=1), including partial
//     beats. Cycles with rx_valid_i=0 change nothing.
//   Compare mask: full word, except on a last beat with vldb!=0, where only the
//     low vldb bytes are compared.
//   FSM HUNT: seed state <= data[31:1] on every full beat and reset match_cnt.
//     On the following beats, compare against the prediction; a match increments
//     match_cnt. A mismatch or a partial beat re-seeds (partial beats never seed).
//     match_cnt == LOCK_CNT -> LOCKED.
//   FSM LOCKED: compare every beat; the LFSR runs free and is never re-seeded.
//     A mismatch increments the errored-word and errored-bit counters
//     (bit count = popcount of the masked XOR) and pulses err_o.
//     LOSS_THRESH consecutive mismatches -> HUNT; any match clears the run count.
//     The word that triggers the loss is still counted.
//   Latency: err_o, locked_o and the counter updates appear 1 cycle after the beat.
//   Frames: at rx_valid_i & rx_last_i, rx_user_i=1 increments bad_frame_cnt_o,
//     otherwise frame_cnt_o. Frames are counted in both HUNT and LOCKED.
//   Counters saturate at all-ones and never wrap. err_bit_cnt_o adds up to 32 per
//     beat and clamps at all-ones.
//   clear_i: zeroes all counters; clear wins over a same-cycle increment (result 0).
//     Lock state and the LFSR are unaffected.
//   Reset mid-frame: immediate return to reset values; the next frame is counted
//     normally.
// CONFIGURATION
//   PRBS_RX_MON_LEN_CHECK_EN defined: count bytes per frame
//     (full beats = 4, last beat = vldb). A last beat whose total != FRAME_BYTES
//     increments bad_frame_cnt_o even if rx_user_i=0.
//   Not defined: length is ignored; the byte counter and FRAME_BYTES logic are absent.
// STRUCTURE
//   prbs_pkg: PRBS31 taps, function prbs31_step(state) -> {word[31:0], state[30:0]},
//     function vldb_mask(vldb) -> [31:0], FSM enum {HUNT, LOCKED}.
//     The package is shared with the PRBS generator.
//   Sub-module prbs_popcount32: combinational 32-bit popcount, 6-bit result.
// TESTING
//   1. Clean PRBS, 4 frames of 256 full beats -> locked_o rises 1 cycle after beat 17;
//      err_word_cnt_o=0; frame_cnt_o=4.
//   2. In LOCKED, flip bits [3:0] of one word -> err_o pulses once;
//      err_bit_cnt_o=4; err_word_cnt_o=1; locked_o stays 1.
//   3. 4 consecutive corrupted words -> err_word_cnt_o=4; locked_o=0 after the 4th;
//      relock after 16 clean words.
//   4. Last beat with vldb=2 and bytes 2-3 garbage -> no error; rx_user_i=1 on a
//      last beat -> bad_frame_cnt_o=1.
//   5. clear_i on the same cycle as an errored word -> all counters 0 next cycle;
//      locked_o unchanged. Preload err_word_cnt_o near all-ones -> it holds at all-ones.
//   6. With PRBS_RX_MON_LEN_CHECK_EN and FRAME_BYTES=1024, send a 1022-byte clean
//      frame -> bad_frame_cnt_o=1; without the macro -> frame_cnt_o=1.

Source files
------------

// File: rtl/prbs_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Package  : prbs_pkg                                                      |
// | Purpose  : Shared PRBS-31 definitions for the lane PRBS generator and    |
// |            the RX monitor: tap positions, 32-bit word step function,     |
// |            last-beat byte mask and the monitor FSM state type.           |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
package prbs_pkg;

  // The 31-bit state holds b[m] .. b[m+30] with the oldest bit at index 0,
  // so b[n] = b[n-31] ^ b[n-28] reads state bits 0 and 3.
  localparam int c_prbs31_tap_a = 0;
  localparam int c_prbs31_tap_b = 3;

  typedef enum logic [0:0] {
    HUNT   = 1'b0,
    LOCKED = 1'b1
  } prbs_mon_state_e;

  // Produce the next 32 sequence bits (word[j] is the j-th bit in time) and
  // the state after those 32 bits. Returned as {word[31:0], state[30:0]}.
  function automatic logic [62:0] prbs31_step(input logic [30:0] state);
    logic [30:0] s;
    logic [31:0] word;
    logic        nb;
    s    = state;
    word = '0;
    for (int j = 0; j < 32; j++) begin
      nb      = s[c_prbs31_tap_a] ^ s[c_prbs31_tap_b];
      word[j] = nb;
      s       = {nb, s[30:1]};
    end
    return {word, s};
  endfunction

  // Byte-enable mask for a beat carrying vldb valid bytes (0 means all four).
  function automatic logic [31:0] vldb_mask(input logic [1:0] vldb);
    logic [31:0] m;
    case (vldb)
      2'd1:    m = 32'h0000_00FF;
      2'd2:    m = 32'h0000_FFFF;
      2'd3:    m = 32'h00FF_FFFF;
      default: m = 32'hFFFF_FFFF;
    endcase
    return m;
  endfunction

endpackage
`default_nettype wire

// File: rtl/prbs_popcount32.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : prbs_popcount32                                               |
// | Purpose  : Combinational population count of a 32-bit vector.           |
// | Ports    : i_data  [31:0]  vector to count                              |
// |            o_count [5:0]   number of set bits (0..32)                   |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module prbs_popcount32 (
  input  logic [31:0] i_data,
  output logic [5:0]  o_count
);

  always_comb begin
    o_count = '0;
    for (int i = 0; i < 32; i++) begin
      o_count = o_count + {5'd0, i_data[i]};
    end
  end

endmodule
`default_nettype wire

// File: rtl/prbs_rx_monitor.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : prbs_rx_monitor                                               |
// | Purpose  : PRBS-31 checker for one RX AXIS lane. Self-synchronises to    |
// |            the incoming stream (HUNT -> LOCKED), then counts errored     |
// |            bits/words and good/bad frames with saturating counters.      |
// | Ports    : rx_user_clk_i, rx_user_rst_n_i (async, active low)           |
// |            rx_data_i[31:0], rx_vldb_i[1:0], rx_valid_i, rx_last_i,       |
// |            rx_user_i, clear_i                                            |
// |            locked_o, err_o, err_bit_cnt_o, err_word_cnt_o, frame_cnt_o,  |
// |            bad_frame_cnt_o (all registered, 1 cycle after the beat)      |
// | Config   : PRBS_RX_MON_LEN_CHECK_EN - frames whose byte total differs   |
// |            from FRAME_BYTES are counted as bad.                          |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module prbs_rx_monitor
  import prbs_pkg::*;
#(
  parameter int LOCK_CNT    = 16,
  parameter int LOSS_THRESH = 4,
  parameter int CNT_W       = 32,
  parameter int FRAME_BYTES = 1024
) (
  input  logic             rx_user_clk_i,
  input  logic             rx_user_rst_n_i,
  input  logic [31:0]      rx_data_i,
  input  logic [1:0]       rx_vldb_i,
  input  logic             rx_valid_i,
  input  logic             rx_last_i,
  input  logic             rx_user_i,
  input  logic             clear_i,
  output logic             locked_o,
  output logic             err_o,
  output logic [CNT_W-1:0] err_bit_cnt_o,
  output logic [CNT_W-1:0] err_word_cnt_o,
  output logic [CNT_W-1:0] frame_cnt_o,
  output logic [CNT_W-1:0] bad_frame_cnt_o
);

  localparam int c_match_w = $clog2(LOCK_CNT + 1);
  localparam int c_loss_w  = $clog2(LOSS_THRESH + 1);
  localparam int c_sum_w   = CNT_W + 7;

  localparam logic [c_match_w-1:0] c_match_last = c_match_w'(LOCK_CNT - 1);
  localparam logic [c_match_w-1:0] c_match_one  = {{(c_match_w-1){1'b0}}, 1'b1};
  localparam logic [c_loss_w-1:0]  c_loss_last  = c_loss_w'(LOSS_THRESH - 1);
  localparam logic [c_loss_w-1:0]  c_loss_one   = {{(c_loss_w-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0]     c_cnt_one    = {{(CNT_W-1){1'b0}}, 1'b1};

  // ---------------------------------------------------------------- state
  prbs_mon_state_e        r_state, w_state_nxt;
  logic [30:0]            r_lfsr, w_lfsr_nxt;
  logic                   r_seed_ok, w_seed_ok_nxt;
  logic [c_match_w-1:0]   r_match_cnt, w_match_nxt;
  logic [c_loss_w-1:0]    r_loss_cnt, w_loss_nxt;
  logic                   r_err, w_err_nxt;
  logic [CNT_W-1:0]       r_err_bit_cnt, r_err_word_cnt, r_frame_cnt, r_bad_frame_cnt;

  // ---------------------------------------------------------------- compare
  logic [62:0] w_step;
  logic [31:0] w_pred, w_mask, w_diff;
  logic [30:0] w_lfsr_run;
  logic        w_partial, w_mismatch;
  logic [5:0]  w_diff_bits;

  assign w_step     = prbs31_step(r_lfsr);
  assign w_pred     = w_step[62:31];
  assign w_lfsr_run = w_step[30:0];
  assign w_partial  = rx_last_i && (rx_vldb_i != 2'd0);
  assign w_mask     = w_partial ? vldb_mask(rx_vldb_i) : 32'hFFFF_FFFF;
  assign w_diff     = (rx_data_i ^ w_pred) & w_mask;
  assign w_mismatch = |w_diff;

  prbs_popcount32 u_popcount (
    .i_data  (w_diff),
    .o_count (w_diff_bits)
  );

  // ---------------------------------------------------------------- FSM
  always_ff @(posedge rx_user_clk_i or negedge rx_user_rst_n_i) begin
    if (!rx_user_rst_n_i) begin
      r_state     <= HUNT;
      r_lfsr      <= '0;
      r_seed_ok   <= 1'b0;
      r_match_cnt <= '0;
      r_loss_cnt  <= '0;
      r_err       <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_lfsr      <= w_lfsr_nxt;
      r_seed_ok   <= w_seed_ok_nxt;
      r_match_cnt <= w_match_nxt;
      r_loss_cnt  <= w_loss_nxt;
      r_err       <= w_err_nxt;
    end
  end

  always_comb begin
    w_state_nxt   = r_state;
    w_lfsr_nxt    = r_lfsr;
    w_seed_ok_nxt = r_seed_ok;
    w_match_nxt   = r_match_cnt;
    w_loss_nxt    = r_loss_cnt;
    w_err_nxt     = 1'b0;
    if (rx_valid_i) begin
      case (r_state)
        HUNT: begin
          if (!w_partial) begin
            // Every full beat loads the state from the data; on a match this
            // equals the free-running prediction, so one load serves both.
            w_lfsr_nxt    = rx_data_i[31:1];
            w_seed_ok_nxt = 1'b1;
            if (r_seed_ok && !w_mismatch) begin
              if (r_match_cnt == c_match_last) begin
                w_state_nxt = LOCKED;
                w_match_nxt = '0;
                w_loss_nxt  = '0;
              end else begin
                w_match_nxt = r_match_cnt + c_match_one;
              end
            end else begin
              w_match_nxt = '0;
            end
          end else begin
            // A partial beat cannot provide 31 seed bits: restart the hunt.
            w_lfsr_nxt    = w_lfsr_run;
            w_seed_ok_nxt = 1'b0;
            w_match_nxt   = '0;
          end
        end
        LOCKED: begin
          w_lfsr_nxt = w_lfsr_run;
          if (w_mismatch) begin
            w_err_nxt = 1'b1;
            if (r_loss_cnt == c_loss_last) begin
              // The free-running state stays valid, so the hunt can keep
              // comparing against it rather than waiting for a new seed.
              w_state_nxt = HUNT;
              w_match_nxt = '0;
              w_loss_nxt  = '0;
            end else begin
              w_loss_nxt = r_loss_cnt + c_loss_one;
            end
          end else begin
            w_loss_nxt = '0;
          end
        end
        default: w_state_nxt = HUNT;
      endcase
    end
  end

  // ---------------------------------------------------------------- frames
  logic w_frame_end, w_len_bad;
  assign w_frame_end = rx_valid_i && rx_last_i;

`ifdef PRBS_RX_MON_LEN_CHECK_EN
  // Wide enough that the saturated value is always above FRAME_BYTES.
  localparam int c_len_w = $clog2(FRAME_BYTES + 4) + 1;

  logic [c_len_w-1:0] r_byte_cnt, w_byte_total;
  logic [c_len_w:0]   w_byte_sum;
  logic [2:0]         w_beat_bytes;

  assign w_beat_bytes = w_partial ? {1'b0, rx_vldb_i} : 3'd4;
  assign w_byte_sum   = {1'b0, r_byte_cnt} + (c_len_w + 1)'(w_beat_bytes);
  assign w_byte_total = w_byte_sum[c_len_w] ? '1 : w_byte_sum[c_len_w-1:0];
  assign w_len_bad    = (w_byte_total != c_len_w'(FRAME_BYTES));

  always_ff @(posedge rx_user_clk_i or negedge rx_user_rst_n_i) begin
    if (!rx_user_rst_n_i) begin
      r_byte_cnt <= '0;
    end else if (rx_valid_i) begin
      r_byte_cnt <= rx_last_i ? '0 : w_byte_total;
    end
  end
`else
  logic w_unused_frame_bytes;
  assign w_unused_frame_bytes = (FRAME_BYTES != 0);
  assign w_len_bad            = 1'b0;
`endif

  // ---------------------------------------------------------------- counters
  logic [c_sum_w-1:0] w_bit_sum;
  logic [CNT_W-1:0]   w_bit_sat;

  assign w_bit_sum = {7'd0, r_err_bit_cnt} + {{(c_sum_w-6){1'b0}}, w_diff_bits};
  assign w_bit_sat = (w_bit_sum[c_sum_w-1:CNT_W] != '0) ? '1 : w_bit_sum[CNT_W-1:0];

  always_ff @(posedge rx_user_clk_i or negedge rx_user_rst_n_i) begin
    if (!rx_user_rst_n_i) begin
      r_err_bit_cnt   <= '0;
      r_err_word_cnt  <= '0;
      r_frame_cnt     <= '0;
      r_bad_frame_cnt <= '0;
    end else if (clear_i) begin
      r_err_bit_cnt   <= '0;
      r_err_word_cnt  <= '0;
      r_frame_cnt     <= '0;
      r_bad_frame_cnt <= '0;
    end else begin
      if (w_err_nxt) begin
        r_err_bit_cnt <= w_bit_sat;
        if (!(&r_err_word_cnt)) r_err_word_cnt <= r_err_word_cnt + c_cnt_one;
      end
      if (w_frame_end) begin
        if (rx_user_i || w_len_bad) begin
          if (!(&r_bad_frame_cnt)) r_bad_frame_cnt <= r_bad_frame_cnt + c_cnt_one;
        end else begin
          if (!(&r_frame_cnt)) r_frame_cnt <= r_frame_cnt + c_cnt_one;
        end
      end
    end
  end

  assign locked_o        = (r_state == LOCKED);
  assign err_o           = r_err;
  assign err_bit_cnt_o   = r_err_bit_cnt;
  assign err_word_cnt_o  = r_err_word_cnt;
  assign frame_cnt_o     = r_frame_cnt;
  assign bad_frame_cnt_o = r_bad_frame_cnt;

endmodule
`default_nettype wire

// File: tb/tb_prbs_rx_monitor.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : tb_prbs_rx_monitor                                            |
// | Purpose  : Self-checking bench for prbs_rx_monitor: directed vector      |
// |            table, hand sequences and randomized beats against a          |
// |            bit-stream reference model. A second instance with narrow     |
// |            counters exercises saturation.                                |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module tb_prbs_rx_monitor;

  localparam int LOCK_CNT    = 16;
  localparam int LOSS_THRESH = 4;
  localparam int CNT_W       = 32;
  localparam int SMALL_W     = 4;
  localparam int FRAME_BYTES = 1024;
`ifdef PRBS_RX_MON_LEN_CHECK_EN
  localparam bit LEN_CHK = 1'b1;
`else
  localparam bit LEN_CHK = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] rx_data = '0;
  logic [1:0]  rx_vldb = '0;
  logic        rx_valid = 1'b0, rx_last = 1'b0, rx_user = 1'b0, clear = 1'b0;

  logic               locked, err, s_locked, s_err;
  logic [CNT_W-1:0]   bits_c, words_c, frames_c, bad_c;
  logic [SMALL_W-1:0] s_bits, s_words, s_frames, s_bad;

  always #5 clk = ~clk;

  prbs_rx_monitor #(.LOCK_CNT(LOCK_CNT), .LOSS_THRESH(LOSS_THRESH), .CNT_W(CNT_W),
                    .FRAME_BYTES(FRAME_BYTES)) dut (
    .rx_user_clk_i(clk), .rx_user_rst_n_i(rst_n), .rx_data_i(rx_data),
    .rx_vldb_i(rx_vldb), .rx_valid_i(rx_valid), .rx_last_i(rx_last),
    .rx_user_i(rx_user), .clear_i(clear), .locked_o(locked), .err_o(err),
    .err_bit_cnt_o(bits_c), .err_word_cnt_o(words_c), .frame_cnt_o(frames_c),
    .bad_frame_cnt_o(bad_c));

  prbs_rx_monitor #(.LOCK_CNT(LOCK_CNT), .LOSS_THRESH(LOSS_THRESH), .CNT_W(SMALL_W),
                    .FRAME_BYTES(FRAME_BYTES)) dut_s (
    .rx_user_clk_i(clk), .rx_user_rst_n_i(rst_n), .rx_data_i(rx_data),
    .rx_vldb_i(rx_vldb), .rx_valid_i(rx_valid), .rx_last_i(rx_last),
    .rx_user_i(rx_user), .clear_i(clear), .locked_o(s_locked), .err_o(s_err),
    .err_bit_cnt_o(s_bits), .err_word_cnt_o(s_words), .frame_cnt_o(s_frames),
    .bad_frame_cnt_o(s_bad));

  int n_checks = 0;
  int n_errors = 0;

  // Transmitted stream: last 31 sequence bits, oldest first.
  bit tx_hist[$];

  // Reference model: the receiver's view of the sequence plus abstract status.
  bit     m_hist[$];
  bit     m_locked, m_seed_ok, m_err;
  int     m_match, m_run;
  longint m_bits, m_words, m_frames, m_bad;
`ifdef PRBS_RX_MON_LEN_CHECK_EN
  int     m_bytes;
`endif

  typedef struct {
    logic [31:0] x;
    logic        last;
    logic [1:0]  vldb;
    logic        user, clr, e_err, e_locked;
    int          e_words, e_bits, e_frames, e_bad;
  } vec_t;
  vec_t tbl [13];

  function automatic longint sat(input longint v, input int w);
    longint mx;
    mx = (longint'(1) << w) - 1;
    return (v > mx) ? mx : v;
  endfunction

  task automatic chk(input string name, input longint act, input longint exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic check_all();
    chk("locked", locked, m_locked);
    chk("err", err, m_err);
    chk("err_bits", bits_c, sat(m_bits, CNT_W));
    chk("err_words", words_c, sat(m_words, CNT_W));
    chk("frames", frames_c, sat(m_frames, CNT_W));
    chk("bad_frames", bad_c, sat(m_bad, CNT_W));
    chk("s_locked", s_locked, m_locked);
    chk("s_err", s_err, m_err);
    chk("s_err_bits", s_bits, sat(m_bits, SMALL_W));
    chk("s_err_words", s_words, sat(m_words, SMALL_W));
    chk("s_frames", s_frames, sat(m_frames, SMALL_W));
    chk("s_bad_frames", s_bad, sat(m_bad, SMALL_W));
  endtask

  task automatic tx_next(output logic [31:0] w);
    bit nb;
    for (int j = 0; j < 32; j++) begin
      nb = tx_hist[0] ^ tx_hist[3];     // b[n-31] ^ b[n-28]
      void'(tx_hist.pop_front());
      tx_hist.push_back(nb);
      w[j] = nb;
    end
  endtask

  task automatic model_reset();
    m_hist.delete();
    for (int j = 0; j < 31; j++) m_hist.push_back(1'b0);
    m_locked = 0; m_seed_ok = 0; m_err = 0; m_match = 0; m_run = 0;
    m_bits = 0; m_words = 0; m_frames = 0; m_bad = 0;
`ifdef PRBS_RX_MON_LEN_CHECK_EN
    m_bytes = 0;
`endif
  endtask

  task automatic model_step(input logic [31:0] d, input logic v, input logic last,
                            input logic [1:0] vl, input logic user, input logic clr);
    logic [31:0] pred, mask, diff;
    bit full, nb, bad;
    m_err = 0;
    if (v) begin
      full = !(last && vl != 2'd0);
      for (int j = 0; j < 32; j++) begin
        nb = m_hist[0] ^ m_hist[3];
        void'(m_hist.pop_front());
        m_hist.push_back(nb);
        pred[j] = nb;
      end
      if (!m_locked) begin
        if (full) begin
          if (m_seed_ok && d == pred) m_match++;
          else m_match = 0;
          m_hist.delete();
          for (int j = 1; j < 32; j++) m_hist.push_back(d[j]);
          m_seed_ok = 1;
          if (m_match == LOCK_CNT) begin m_locked = 1; m_match = 0; m_run = 0; end
        end else begin
          m_match = 0; m_seed_ok = 0;
        end
      end else begin
        mask = full ? 32'hFFFF_FFFF : (32'hFFFF_FFFF >> (8 * (4 - int'(vl))));
        diff = (d ^ pred) & mask;
        if (diff != 0) begin
          m_err = 1; m_words++; m_bits += $countones(diff); m_run++;
          if (m_run == LOSS_THRESH) begin m_locked = 0; m_run = 0; m_match = 0; end
        end else begin
          m_run = 0;
        end
      end
      bad = user;
`ifdef PRBS_RX_MON_LEN_CHECK_EN
      m_bytes += full ? 4 : int'(vl);
      if (last) begin
        if (m_bytes != FRAME_BYTES) bad = 1;
        m_bytes = 0;
      end
`endif
      if (last) begin
        if (bad) m_bad++;
        else m_frames++;
      end
    end
    if (clr) begin m_bits = 0; m_words = 0; m_frames = 0; m_bad = 0; end
  endtask

  // Called at a negedge; applies one cycle and checks just before the next edge.
  task automatic beat(input logic [31:0] d, input logic v, input logic last,
                      input logic [1:0] vl, input logic user, input logic clr);
    rx_data = d; rx_valid = v; rx_last = last; rx_vldb = vl; rx_user = user; clear = clr;
    @(posedge clk);
    model_step(d, v, last, vl, user, clr);
    @(negedge clk);
    check_all();
  endtask

  task automatic send(input logic [31:0] x, input logic last, input logic [1:0] vl,
                      input logic user, input logic clr);
    logic [31:0] w;
    tx_next(w);
    beat(w ^ x, 1'b1, last, vl, user, clr);
  endtask

  task automatic do_reset();
    rx_valid = 0; rx_last = 0; rx_user = 0; clear = 0;
    rst_n = 0;
    #1;
    model_reset();
    check_all();
    @(posedge clk);
    @(negedge clk);
    rst_n = 1;
  endtask

  initial begin
    // x, last, vldb, user, clr, err, locked, words, bits, frames, bad
    tbl[0]  = '{32'h0000_000F, 0, 0, 0, 0, 1, 1, 1, 4,  4, 0};
    tbl[1]  = '{32'h0000_0000, 0, 0, 0, 0, 0, 1, 1, 4,  4, 0};
    tbl[2]  = '{32'h0000_0001, 0, 0, 0, 0, 1, 1, 2, 5,  4, 0};
    tbl[3]  = '{32'h0000_0003, 0, 0, 0, 0, 1, 1, 3, 7,  4, 0};
    tbl[4]  = '{32'h0000_0007, 0, 0, 0, 0, 1, 1, 4, 10, 4, 0};
    tbl[5]  = '{32'h0000_000F, 0, 0, 0, 0, 1, 0, 5, 14, 4, 0};
    tbl[6]  = '{32'hFFFF_0000, 1, 2, 0, 0, 0, 1, 5, 14, LEN_CHK ? 4 : 5, LEN_CHK ? 1 : 0};
    tbl[7]  = '{32'h0000_0000, 1, 0, 1, 0, 0, 1, 5, 14, LEN_CHK ? 4 : 5, LEN_CHK ? 2 : 1};
    tbl[8]  = '{32'h0000_FF00, 1, 1, 0, 0, 0, 1, 5, 14, LEN_CHK ? 4 : 6, LEN_CHK ? 3 : 1};
    tbl[9]  = '{32'h0001_0000, 1, 3, 0, 0, 1, 1, 6, 15, LEN_CHK ? 4 : 7, LEN_CHK ? 4 : 1};
    tbl[10] = '{32'h0000_000F, 0, 0, 0, 1, 1, 1, 0, 0,  0, 0};
    tbl[11] = '{32'h0000_0000, 0, 0, 0, 0, 0, 1, 0, 0,  0, 0};
    tbl[12] = '{32'h0000_0001, 1, 0, 0, 0, 1, 1, 1, 1,  LEN_CHK ? 0 : 1, LEN_CHK ? 1 : 0};

    tx_hist.push_back(1'b1);
    for (int j = 1; j < 31; j++) tx_hist.push_back(1'($urandom));

    @(negedge clk);
    do_reset();
    chk("reset_locked", locked, 0);
    chk("reset_words", words_c, 0);

    // Clean stream: 4 frames of 256 full beats; lock becomes visible after beat 17.
    for (int i = 0; i < 1024; i++) begin
      send(32'h0, (i % 256) == 255, 2'd0, 1'b0, 1'b0);
      if (i == 15) chk("lock_before_17", locked, 0);
      if (i == 16) chk("lock_after_17", locked, 1);
    end
    chk("clean_words", words_c, 0);
    chk("clean_frames", frames_c, 4);

    // Errored words and loss of lock.
    for (int r = 0; r <= 5; r++) begin
      send(tbl[r].x, tbl[r].last, tbl[r].vldb, tbl[r].user, tbl[r].clr);
      chk($sformatf("tbl%0d_err", r), err, tbl[r].e_err);
      chk($sformatf("tbl%0d_locked", r), locked, tbl[r].e_locked);
      chk($sformatf("tbl%0d_words", r), words_c, tbl[r].e_words);
      chk($sformatf("tbl%0d_bits", r), bits_c, tbl[r].e_bits);
      chk($sformatf("tbl%0d_frames", r), frames_c, tbl[r].e_frames);
      chk($sformatf("tbl%0d_bad", r), bad_c, tbl[r].e_bad);
    end

    // Relock from the free-running prediction after 16 clean words.
    for (int i = 0; i < 16; i++) begin
      send(32'h0, 1'b0, 2'd0, 1'b0, 1'b0);
      chk("relock", locked, (i == 15) ? 1 : 0);
    end

    // Partial-beat masking, frame status, clear priority.
    for (int r = 6; r <= 12; r++) begin
      send(tbl[r].x, tbl[r].last, tbl[r].vldb, tbl[r].user, tbl[r].clr);
      chk($sformatf("tbl%0d_err", r), err, tbl[r].e_err);
      chk($sformatf("tbl%0d_locked", r), locked, tbl[r].e_locked);
      chk($sformatf("tbl%0d_words", r), words_c, tbl[r].e_words);
      chk($sformatf("tbl%0d_bits", r), bits_c, tbl[r].e_bits);
      chk($sformatf("tbl%0d_frames", r), frames_c, tbl[r].e_frames);
      chk($sformatf("tbl%0d_bad", r), bad_c, tbl[r].e_bad);
    end

    // Saturation on the narrow-counter instance.
    for (int i = 0; i < 20; i++) begin
      send(32'h0, 1'b0, 2'd0, 1'b0, 1'b0);
      send(32'h1, 1'b0, 2'd0, 1'b0, 1'b0);
    end
    chk("sat_words_small", s_words, 15);
    chk("sat_bits_small", s_bits, 15);
    chk("sat_words_main", words_c, 21);
    chk("sat_locked", locked, 1);

    // Frame-length handling: close the current frame under clear, then 1022 bytes.
    send(32'h0, 1'b1, 2'd0, 1'b0, 1'b1);
    chk("clear_frames", frames_c, 0);
    for (int i = 0; i < 256; i++) send(32'h0, i == 255, (i == 255) ? 2'd2 : 2'd0, 1'b0, 1'b0);
    chk("len_good", frames_c, LEN_CHK ? 0 : 1);
    chk("len_bad", bad_c, LEN_CHK ? 1 : 0);

    // Partial beat during HUNT restarts the hunt.
    do_reset();
    for (int i = 0; i < 10; i++) send(32'h0, 1'b0, 2'd0, 1'b0, 1'b0);
    send(32'h0, 1'b1, 2'd1, 1'b0, 1'b0);
    for (int i = 0; i < 17; i++) begin
      send(32'h0, 1'b0, 2'd0, 1'b0, 1'b0);
      chk("hunt_partial", locked, (i == 16) ? 1 : 0);
    end

    // Randomized traffic including bursts, idles, clears and mid-frame resets.
    begin
      int burst;
      logic [31:0] x;
      burst = 0;
      for (int i = 0; i < 4000; i++) begin
        if ($urandom_range(0, 499) == 0) begin
          do_reset();
        end else if ($urandom_range(0, 9) == 0) begin
          beat($urandom, 1'b0, 1'($urandom), 2'($urandom), 1'($urandom), $urandom_range(0, 99) == 0);
        end else begin
          if ($urandom_range(0, 149) == 0) burst = $urandom_range(1, 6);
          if (burst > 0) begin
            x = $urandom | 32'h1;
            burst--;
          end else begin
            x = ($urandom_range(0, 99) < 3) ? $urandom : 32'h0;
          end
          send(x, $urandom_range(0, 24) == 0, 2'($urandom), $urandom_range(0, 4) == 0,
               $urandom_range(0, 149) == 0);
        end
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
